// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_pkg.sv
// ============================================================================
// Module   : ddr2_blk_rdwr_pkg
// Purpose  : Shared widths and types for the DDR2 read-path 72b->64b repacker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ddr2_blk_rdwr_pkg;

  localparam int IN_W         = 72;
  localparam int OUT_W        = 64;
  localparam int BYTE_W       = 8;
  localparam int BYTE_CNT_W   = 4;
  localparam int MAX_RESIDUAL = 8;

  typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

  localparam byte_cnt_t RESIDUAL_FULL = byte_cnt_t'(MAX_RESIDUAL);

endpackage

`default_nettype wire

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b_fifo.sv
// ============================================================================
// Module   : fallthrough_small_fifo_arst
// Purpose  : First-word-fallthrough register FIFO with async active-low reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fallthrough_small_fifo_arst #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  output logic             full,
  output logic             nearly_full,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  input  logic             rd_en,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int PTR_W = MAX_DEPTH_BITS;
  localparam int CNT_W = MAX_DEPTH_BITS + 1;
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  localparam logic [CNT_W-1:0] FULL_CNT        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NEARLY_FULL_CNT = CNT_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_acc;
  logic             rd_acc;

  assign full        = (count_q == FULL_CNT);
  assign nearly_full = (count_q >= NEARLY_FULL_CNT);
  assign empty       = (count_q == '0);
  assign dout        = mem[rd_ptr_q];

  // Writes into a truly full buffer are dropped even if a pop happens this cycle.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/ddr2_blk_rdwr_fifo_72b_2_64b.sv
// ============================================================================
// Module   : ddr2_blk_rdwr_fifo_72b_2_64b
// Purpose  : Repacks a 72-bit MSB-first byte stream into 64-bit words.
//            Optional sticky error flags: DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ddr2_blk_rdwr_fifo_72b_2_64b
  import ddr2_blk_rdwr_pkg::*;
#(
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              rd_en,
  output logic [OUT_W-1:0]  rd_data,
  output logic [OUT_W-1:0]  rd_data_d1,
  output logic              empty
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
  ,
  output logic              err_ovfl,
  output logic              err_udfl
`endif
);

  logic [IN_W-1:0]  fifo_dout;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_nearly_full;
  logic             fifo_pop;

  byte_cnt_t        byte_cnt_q, byte_cnt_d;
  logic [OUT_W-1:0] residual_q, residual_d;
  logic [OUT_W-1:0] rd_data_d1_q;
  logic             res_full;
  logic             rd_ok;

  fallthrough_small_fifo_arst #(
    .WIDTH          (IN_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .full        (fifo_full),
    .nearly_full (fifo_nearly_full),
    .din         (wr_data),
    .wr_en       (wr_en),
    .dout        (fifo_dout),
    .empty       (fifo_empty),
    .rd_en       (fifo_pop),
    .clk         (clk),
    .rst_n       (rst_n)
  );

  assign res_full   = (byte_cnt_q == RESIDUAL_FULL);
  assign empty      = ~(res_full | ~fifo_empty);
  assign full       = fifo_nearly_full;
  assign rd_ok      = rd_en & ~empty;
  assign rd_data_d1 = rd_data_d1_q;

  // Each read emits the top 64 bits of {residual bytes, buffered word}; the rest
  // becomes the new left-aligned residual, growing by one byte per pop.
  always_comb begin
    rd_data    = '0;
    residual_d = residual_q;
    byte_cnt_d = byte_cnt_q;
    fifo_pop   = 1'b0;
    if (rd_ok) begin
      fifo_pop   = 1'b1;
      byte_cnt_d = byte_cnt_q + byte_cnt_t'(1);
      case (byte_cnt_q)
        4'd0: begin
          rd_data    = fifo_dout[71:8];
          residual_d = {fifo_dout[7:0], 56'h0};
        end
        4'd1: begin
          rd_data    = {residual_q[63:56], fifo_dout[71:16]};
          residual_d = {fifo_dout[15:0], 48'h0};
        end
        4'd2: begin
          rd_data    = {residual_q[63:48], fifo_dout[71:24]};
          residual_d = {fifo_dout[23:0], 40'h0};
        end
        4'd3: begin
          rd_data    = {residual_q[63:40], fifo_dout[71:32]};
          residual_d = {fifo_dout[31:0], 32'h0};
        end
        4'd4: begin
          rd_data    = {residual_q[63:32], fifo_dout[71:40]};
          residual_d = {fifo_dout[39:0], 24'h0};
        end
        4'd5: begin
          rd_data    = {residual_q[63:24], fifo_dout[71:48]};
          residual_d = {fifo_dout[47:0], 16'h0};
        end
        4'd6: begin
          rd_data    = {residual_q[63:16], fifo_dout[71:56]};
          residual_d = {fifo_dout[55:0], 8'h0};
        end
        4'd7: begin
          rd_data    = {residual_q[63:8], fifo_dout[71:64]};
          residual_d = fifo_dout[63:0];
        end
        4'd8: begin
          rd_data    = residual_q;
          residual_d = '0;
          byte_cnt_d = '0;
          fifo_pop   = 1'b0;
        end
        default: begin
          rd_data    = '0;
          byte_cnt_d = byte_cnt_q;
          fifo_pop   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q   <= '0;
      residual_q   <= '0;
      rd_data_d1_q <= '0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      residual_q   <= residual_d;
      rd_data_d1_q <= rd_data;
    end
  end

`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
  logic err_ovfl_q, err_ovfl_d;
  logic err_udfl_q, err_udfl_d;

  always_comb begin
    err_ovfl_d = err_ovfl_q | (wr_en & fifo_full);
    err_udfl_d = err_udfl_q | (rd_en & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovfl_q <= 1'b0;
      err_udfl_q <= 1'b0;
    end else begin
      err_ovfl_q <= err_ovfl_d;
      err_udfl_q <= err_udfl_d;
    end
  end

  assign err_ovfl = err_ovfl_q;
  assign err_udfl = err_udfl_q;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr2_blk_rdwr_fifo_72b_2_64b.sv
// ============================================================================
// Module   : tb_ddr2_blk_rdwr_fifo_72b_2_64b
// Purpose  : Self-checking bench for the 72b->64b read-path repacker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ddr2_blk_rdwr_fifo_72b_2_64b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [71:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        full;
  logic        rd_en = 1'b0;
  logic [63:0] rd_data;
  logic [63:0] rd_data_d1;
  logic        empty;
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
  logic        err_ovfl;
  logic        err_udfl;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered words plus a byte queue of residual stream bytes.
  logic [71:0] m_buf[$];
  logic [7:0]  m_res[$];
  logic [63:0] m_d1 = '0;
  logic        m_ovfl = 1'b0;
  logic        m_udfl = 1'b0;
  logic [63:0] exp_rd = '0;
  logic        exp_empty = 1'b1;
  logic        exp_full = 1'b0;

  always #5 clk = ~clk;

  ddr2_blk_rdwr_fifo_72b_2_64b #(.FIFO_DEPTH_BITS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_data_d1 (rd_data_d1),
    .empty      (empty)
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
    ,
    .err_ovfl   (err_ovfl),
    .err_udfl   (err_udfl)
`endif
  );

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] inc_out(input int j);
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) r = {r[55:0], 8'(8 * j + i)};
    return r;
  endfunction

  function automatic logic [71:0] inc_in(input int j);
    logic [71:0] r = '0;
    for (int i = 0; i < 9; i++) r = {r[63:0], 8'(9 * j + i)};
    return r;
  endfunction

  // Drive one cycle of inputs, derive expected outputs from the model, go to negedge.
  task automatic drive(input logic wr, input logic [71:0] d, input logic rd);
    logic [7:0]  t[$];
    logic [71:0] w;
    wr_en = wr; wr_data = d; rd_en = rd;
    exp_empty = !((m_res.size() == 8) || (m_buf.size() != 0));
    exp_full  = (m_buf.size() >= 3);
    exp_rd    = '0;
    if (rd && !exp_empty) begin
      t = m_res;
      if (m_res.size() != 8) begin
        w = m_buf[0];
        for (int i = 8; i >= 0; i--) t.push_back(w[i*8 +: 8]);
      end
      for (int i = 0; i < 8; i++) exp_rd = {exp_rd[55:0], t[i]};
    end
    @(negedge clk);
  endtask

  // Advance through the clock edge and apply the model update.
  task automatic commit();
    logic [71:0] w;
    int pre;
    pre = m_buf.size();
    @(posedge clk);
    if (rd_en && !exp_empty) begin
      if (m_res.size() == 8) m_res.delete();
      else begin
        w = m_buf.pop_front();
        for (int i = 8; i >= 0; i--) m_res.push_back(w[i*8 +: 8]);
        for (int i = 0; i < 8; i++) void'(m_res.pop_front());
      end
    end
    if (wr_en) begin
      if (pre < 4) m_buf.push_back(wr_data);
      else m_ovfl = 1'b1;
    end
    if (rd_en && exp_empty) m_udfl = 1'b1;
    m_d1 = exp_rd;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL rst_full got=%0b exp=0", full); end
    n_checks++; if (rd_data_d1 !== 64'h0) begin n_errors++; $display("FAIL rst_d1 got=%h exp=0", rd_data_d1); end
    m_buf.delete(); m_res.delete();
    m_d1 = '0; m_ovfl = 1'b0; m_udfl = 1'b0; exp_rd = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(1'b0, '0, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    n_checks++; if (rd_data !== 64'h0) begin n_errors++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    n_checks++; if (dut.byte_cnt_q !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.byte_cnt_q); end
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
    n_checks++; if ({err_ovfl, err_udfl} !== 2'b00) begin n_errors++; $display("FAIL reset_err got=%b exp=00", {err_ovfl, err_udfl}); end
`endif
    commit();
  endtask

  task automatic test_underflow();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++; if (rd_data !== 64'h0) begin n_errors++; $display("FAIL udfl_rd got=%h exp=0", rd_data); end
      n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL udfl_empty got=%0b exp=1", empty); end
      commit();
    end
    n_checks++; if (dut.byte_cnt_q !== 4'd0) begin n_errors++; $display("FAIL udfl_cnt got=%0d exp=0", dut.byte_cnt_q); end
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
    n_checks++; if (err_udfl !== 1'b1) begin n_errors++; $display("FAIL udfl_flag got=%0b exp=1", err_udfl); end
    n_checks++; if (err_ovfl !== 1'b0) begin n_errors++; $display("FAIL udfl_ovfl got=%0b exp=0", err_ovfl); end
`endif
  endtask

  task automatic test_pair();
    logic [63:0] want [2];
    want[0] = 64'h0001020304050607;
    want[1] = 64'h08090A0B0C0D0E0F;
    apply_reset();
    drive(1'b1, 72'h00_0102030405060708, 1'b0); commit();
    drive(1'b1, 72'h09_0A0B0C0D0E0F1011, 1'b0); commit();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++; if (rd_data !== want[i]) begin n_errors++; $display("FAIL pair_rd%0d got=%h exp=%h", i, rd_data, want[i]); end
      n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL pair_model%0d got=%h exp=%h", i, rd_data, exp_rd); end
      commit();
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (rd_data_d1 !== want[1]) begin n_errors++; $display("FAIL pair_d1 got=%h exp=%h", rd_data_d1, want[1]); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL pair_empty got=%0b exp=1", empty); end
    n_checks++; if (dut.byte_cnt_q !== 4'd2) begin n_errors++; $display("FAIL pair_cnt got=%0d exp=2", dut.byte_cnt_q); end
    n_checks++; if (dut.residual_q !== 64'h1011000000000000) begin n_errors++; $display("FAIL pair_res got=%h exp=1011000000000000", dut.residual_q); end
    commit();
  endtask

  task automatic test_stream9();
    int outs = 0, sent = 0, cyc = 0;
    logic wr;
    apply_reset();
    while (outs < 9 && cyc < 100) begin
      wr = (sent < 8) && !full;
      drive(wr, inc_in(sent), 1'b1);
      n_checks++; if (empty !== exp_empty) begin n_errors++; $display("FAIL stream_empty got=%0b exp=%0b", empty, exp_empty); end
      if (!exp_empty) begin
        n_checks++; if (rd_data !== inc_out(outs)) begin n_errors++; $display("FAIL stream_rd%0d got=%h exp=%h", outs, rd_data, inc_out(outs)); end
        outs++;
      end
      commit();
      if (wr) sent++;
      cyc++;
    end
    n_checks++; if (outs != 9) begin n_errors++; $display("FAIL stream_count got=%0d exp=9", outs); end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL stream_final_empty got=%0b exp=1", empty); end
    n_checks++; if (dut.byte_cnt_q !== 4'd0) begin n_errors++; $display("FAIL stream_final_cnt got=%0d exp=0", dut.byte_cnt_q); end
    commit();
  endtask

  task automatic test_overflow();
    int outs = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, rnd72(), 1'b0);
      n_checks++; if (full !== exp_full) begin n_errors++; $display("FAIL ovfl_full%0d got=%0b exp=%0b", i, full, exp_full); end
      if (i >= 3) begin
        n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL ovfl_full_after3 got=%0b exp=1", full); end
      end
      commit();
    end
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
    n_checks++; if (err_ovfl !== 1'b1) begin n_errors++; $display("FAIL ovfl_flag got=%0b exp=1", err_ovfl); end
`endif
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, '0, 1'b1);
      n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL ovfl_rd got=%h exp=%h", rd_data, exp_rd); end
      n_checks++; if (empty !== exp_empty) begin n_errors++; $display("FAIL ovfl_empty got=%0b exp=%0b", empty, exp_empty); end
      if (!exp_empty) outs++;
      commit();
      if (exp_empty) break;
    end
    n_checks++; if (outs != 4) begin n_errors++; $display("FAIL ovfl_outs got=%0d exp=4", outs); end
  endtask

  task automatic test_reset_midstream();
    int reads = 0, sent = 0, cyc = 0;
    logic wr;
    apply_reset();
    while (reads < 5 && cyc < 50) begin
      wr = (sent < 6) && !full;
      drive(wr, rnd72(), 1'b1);
      n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL mid_rd got=%h exp=%h", rd_data, exp_rd); end
      if (!exp_empty) reads++;
      commit();
      if (wr) sent++;
      cyc++;
    end
    n_checks++; if (dut.byte_cnt_q !== 4'd5) begin n_errors++; $display("FAIL mid_cnt got=%0d exp=5", dut.byte_cnt_q); end
    apply_reset();
    drive(1'b1, 72'h00_0102030405060708, 1'b0); commit();
    drive(1'b0, '0, 1'b1);
    n_checks++; if (rd_data !== 64'h0001020304050607) begin n_errors++; $display("FAIL mid_restart got=%h exp=0001020304050607", rd_data); end
    commit();
  endtask

  task automatic test_random();
    logic wr, rd;
    apply_reset();
    for (int c = 0; c < 192; c++) begin
      if (c < 72) begin
        wr = !full && ($urandom_range(0, 15) != 0);
        rd = 1'b1;
      end else begin
        wr = ($urandom_range(0, 1) == 1);
        rd = ($urandom_range(0, 1) == 1);
      end
      drive(wr, rnd72(), rd);
      n_checks++; if (rd_data !== exp_rd) begin n_errors++; $display("FAIL rand_rd c=%0d got=%h exp=%h", c, rd_data, exp_rd); end
      n_checks++; if (empty !== exp_empty) begin n_errors++; $display("FAIL rand_empty c=%0d got=%0b exp=%0b", c, empty, exp_empty); end
      n_checks++; if (full !== exp_full) begin n_errors++; $display("FAIL rand_full c=%0d got=%0b exp=%0b", c, full, exp_full); end
      n_checks++; if (rd_data_d1 !== m_d1) begin n_errors++; $display("FAIL rand_d1 c=%0d got=%h exp=%h", c, rd_data_d1, m_d1); end
      commit();
    end
`ifdef DDR2_BLK_RDWR_FIFO_72B_2_64B_ERR_EN
    n_checks++; if ({err_ovfl, err_udfl} !== {m_ovfl, m_udfl}) begin n_errors++; $display("FAIL rand_err got=%b exp=%b", {err_ovfl, err_udfl}, {m_ovfl, m_udfl}); end
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_underflow();
    test_pair();
    test_stream9();
    test_overflow();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
